gpio_bank_ctrl: RTL and testbench
=================================

Name: gpio_bank_ctrl

Overview:
- Parametrised GPIO bank controller for the Azadi SoC user project. It drives up to 32 mprj_io pins.
- It replaces fixed single-direction pin wiring with per-pin output data, output enable, input synchronisation, optional glitch filtering, and maskable edge/level interrupts.
- The host reaches it through a simple single-cycle register bus.
- It sits between the bus fabric and the caravel mprj_io pads and feeds one aggregated interrupt line to the PLIC.

Parameters:
- NUM_GPIO, 16, number of pins (1..32).
- FILTER_CYCLES, 16, consecutive stable cycles required before a filtered input changes (2..65535).
- CNT_W, 16, filter counter width; must satisfy 2^CNT_W > FILTER_CYCLES.

Ports:
- clock  in  1  system clock
- resetb  in  1  synchronous active-low reset
- req_i  in  1  bus request, one-cycle pulse
- we_i  in  1  1 = write, 0 = read
- addr_i  in  6  byte address, word aligned
- wdata_i  in  32  write data
- rdata_o  out  32  read data, valid with rsp_valid_o
- rsp_valid_o  out  1  response strobe
- err_o  out  1  bad-address flag, valid with rsp_valid_o
- gpio_i  in  NUM_GPIO  pad inputs (asynchronous)
- gpio_o  out  NUM_GPIO  pad output data
- gpio_oe_o  out  NUM_GPIO  pad output enable, 1 = drive
- intr_o  out  1  OR of (INTR_STATE & INTR_EN)

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low, sampled on clock rising edge when resetb = 0.
- Reset values: every register 0; gpio_o = 0, gpio_oe_o = 0, intr_o = 0, rsp_valid_o = 0, rdata_o = 0, err_o = 0; sync and filter state 0.
- Register map (bits above NUM_GPIO-1 read 0 and ignore writes):
  - 0x00 DATA_IN: RO, filtered input.
  - 0x04 DATA_OUT: RW.
  - 0x08 DIR: RW, drives gpio_oe_o.
  - 0x0C INTR_EN: RW.
  - 0x10 INTR_STATE: RW1C.
  - 0x14 RISE_EN: RW.
  - 0x18 FALL_EN: RW.
  - 0x1C LVLHI_EN: RW.
  - 0x20 LVLLO_EN: RW.
  - 0x24 FILTER_EN: RW.
  - 0x28 MASKED_OUT: WO, reads 0. Bits [31:16] are a mask and bits [15:0] are data. For each i < min(16, NUM_GPIO) with mask[i] = 1, DATA_OUT[i] <= data[i]; other bits are unchanged.
- Bus:
  - req_i accepted every cycle with no backpressure.
  - Response one cycle later: rsp_valid_o = 1 for exactly one cycle, rdata_o registered.
  - Writes take effect on the acceptance edge, so gpio_o/gpio_oe_o change one cycle after req_i.
  - Address > 0x28: rsp_valid_o = 1, err_o = 1, rdata_o = 0, no state change.
  - A write response has rdata_o = 0.
- Input path:
  - Two-flop synchroniser per pin produces sync.
  - FILTER_EN[i] = 0: filt[i] = sync[i] (registered), so pad-to-DATA_IN latency is 3 cycles.
  - FILTER_EN[i] = 1: the per-pin counter resets to 0 whenever sync[i] != filt[i] is false or sync[i] changes; otherwise it increments. filt[i] <= sync[i] when the counter reaches FILTER_CYCLES-1. A stable change is therefore visible FILTER_CYCLES+3 cycles after the pad edge. Pulses shorter than FILTER_CYCLES cycles are discarded.
  - Toggling FILTER_EN clears that pin's counter. filt holds its value.
- Interrupt detection uses filt and its 1-cycle delayed copy filt_q:
  - event[i] = (RISE_EN & filt & ~filt_q) | (FALL_EN & ~filt & filt_q) | (LVLHI_EN & filt) | (LVLLO_EN & ~filt).
  - INTR_STATE[i] <= (INTR_STATE[i] & ~w1c[i]) | event[i]. A simultaneous set and clear leaves the bit set.
  - Detection is independent of INTR_EN; INTR_EN only masks intr_o.
  - intr_o is registered: asserts one cycle after INTR_STATE & INTR_EN becomes nonzero.
  - Level interrupts re-assert every cycle while the level persists.
- Loopback: output pins still feed the input path, so DATA_IN reflects driven values.
- Reset mid-operation: all state returns to reset values on the next edge. A response pending in that cycle is dropped (rsp_valid_o = 0).

Test Plan:
- Reset and defaults: hold resetb = 0 for 5 cycles with gpio_i = 0xFFFF; read every address -> rdata 0 except DATA_IN = 0xFFFF after release plus 3 cycles; gpio_oe_o = 0, intr_o = 0.
- Output/masked write: DIR = 0xFFFF, DATA_OUT = 0x00FF, then MASKED_OUT = 0x0F00_0A00 -> gpio_o = 0x0AFF one cycle after req; read DATA_OUT = 0x0AFF; read MASKED_OUT = 0.
- Edge interrupt: RISE_EN = 0x0001, INTR_EN = 0x0001, filter off, gpio_i[0] 0->1 -> INTR_STATE = 0x1 at cycle 4 and intr_o = 1 at cycle 5. Write INTR_STATE = 0x1 -> intr_o = 0 two cycles later.
- Glitch filter (FILTER_CYCLES = 16): FILTER_EN = 0x2, RISE_EN = 0x2; a 10-cycle pulse on gpio_i[1] -> DATA_IN[1] stays 0, no interrupt. A 20-cycle pulse -> DATA_IN[1] = 1 at pad edge + 19 and INTR_STATE[1] = 1.
- W1C collision: LVLHI_EN = 0x4 with gpio_i[2] held at 1; write INTR_STATE = 0x4 -> bit 2 reads 1 afterwards and intr_o stays asserted.
- Bad address and mid-op reset: read 0x30 -> err_o = 1, rdata_o = 0. Issue a read of DATA_OUT and pull resetb low in the same cycle -> no rsp_valid_o; all outputs 0.

Source files
------------

// File: rtl/gpio_bank_ctrl.sv
// rtl/gpio_bank_ctrl.sv - GPIO bank with per-pin direction, input filtering and maskable interrupts
module gpio_bank_ctrl #(
  parameter int NUM_GPIO      = 16,
  parameter int FILTER_CYCLES = 16,
  parameter int CNT_W         = 16
) (
  input  logic                clock,
  input  logic                resetb,
  input  logic                req_i,
  input  logic                we_i,
  input  logic [5:0]          addr_i,
  input  logic [31:0]         wdata_i,
  output logic [31:0]         rdata_o,
  output logic                rsp_valid_o,
  output logic                err_o,
  input  logic [NUM_GPIO-1:0] gpio_i,
  output logic [NUM_GPIO-1:0] gpio_o,
  output logic [NUM_GPIO-1:0] gpio_oe_o,
  output logic                intr_o
);

  // Masked writes carry 16 mask/data pairs, so only the low pins are reachable.
  localparam int MASK_N = (NUM_GPIO < 16) ? NUM_GPIO : 16;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

  localparam logic [3:0] IDX_DATA_IN    = 4'h0;
  localparam logic [3:0] IDX_DATA_OUT   = 4'h1;
  localparam logic [3:0] IDX_DIR        = 4'h2;
  localparam logic [3:0] IDX_INTR_EN    = 4'h3;
  localparam logic [3:0] IDX_INTR_STATE = 4'h4;
  localparam logic [3:0] IDX_RISE_EN    = 4'h5;
  localparam logic [3:0] IDX_FALL_EN    = 4'h6;
  localparam logic [3:0] IDX_LVLHI_EN   = 4'h7;
  localparam logic [3:0] IDX_LVLLO_EN   = 4'h8;
  localparam logic [3:0] IDX_FILTER_EN  = 4'h9;
  localparam logic [3:0] IDX_MASKED_OUT = 4'hA;

  logic [NUM_GPIO-1:0] data_out;
  logic [NUM_GPIO-1:0] dir;
  logic [NUM_GPIO-1:0] intr_en;
  logic [NUM_GPIO-1:0] intr_state;
  logic [NUM_GPIO-1:0] rise_en;
  logic [NUM_GPIO-1:0] fall_en;
  logic [NUM_GPIO-1:0] lvlhi_en;
  logic [NUM_GPIO-1:0] lvllo_en;
  logic [NUM_GPIO-1:0] filter_en;

  logic [NUM_GPIO-1:0] sync_1;
  logic [NUM_GPIO-1:0] sync_2;
  logic [NUM_GPIO-1:0] sync_d;
  logic [NUM_GPIO-1:0] filt;
  logic [NUM_GPIO-1:0] filt_q;
  logic [CNT_W-1:0]    cnt [NUM_GPIO];

  logic                addr_ok;
  logic                wr_en;
  logic                rd_en;
  logic [3:0]          reg_idx;
  logic [NUM_GPIO-1:0] wdata_g;
  logic [NUM_GPIO-1:0] w1c;
  logic [NUM_GPIO-1:0] evt;
  logic [31:0]         rd_word;

  // Address decode and per-register write strobes.
  always_comb begin
    addr_ok = (addr_i <= 6'h28);
    wr_en   = req_i & we_i & addr_ok;
    rd_en   = req_i & ~we_i & addr_ok;
    reg_idx = addr_i[5:2];
    wdata_g = wdata_i[NUM_GPIO-1:0];
    w1c     = (wr_en && reg_idx == IDX_INTR_STATE) ? wdata_g : '0;
  end

  // Interrupt sources, evaluated on the filtered input and its previous value.
  always_comb begin
    evt = (rise_en & filt & ~filt_q)
        | (fall_en & ~filt & filt_q)
        | (lvlhi_en & filt)
        | (lvllo_en & ~filt);
  end

  // Read mux; unused upper bits stay zero and MASKED_OUT reads back zero.
  always_comb begin
    rd_word = '0;
    case (reg_idx)
      IDX_DATA_IN:    rd_word[NUM_GPIO-1:0] = filt;
      IDX_DATA_OUT:   rd_word[NUM_GPIO-1:0] = data_out;
      IDX_DIR:        rd_word[NUM_GPIO-1:0] = dir;
      IDX_INTR_EN:    rd_word[NUM_GPIO-1:0] = intr_en;
      IDX_INTR_STATE: rd_word[NUM_GPIO-1:0] = intr_state;
      IDX_RISE_EN:    rd_word[NUM_GPIO-1:0] = rise_en;
      IDX_FALL_EN:    rd_word[NUM_GPIO-1:0] = fall_en;
      IDX_LVLHI_EN:   rd_word[NUM_GPIO-1:0] = lvlhi_en;
      IDX_LVLLO_EN:   rd_word[NUM_GPIO-1:0] = lvllo_en;
      IDX_FILTER_EN:  rd_word[NUM_GPIO-1:0] = filter_en;
      default:        rd_word = '0;
    endcase
  end

  // Control registers written on the acceptance edge.
  always_ff @(posedge clock) begin
    if (!resetb) begin
      data_out  <= '0;
      dir       <= '0;
      intr_en   <= '0;
      rise_en   <= '0;
      fall_en   <= '0;
      lvlhi_en  <= '0;
      lvllo_en  <= '0;
      filter_en <= '0;
    end else if (wr_en) begin
      case (reg_idx)
        IDX_DATA_OUT:  data_out  <= wdata_g;
        IDX_DIR:       dir       <= wdata_g;
        IDX_INTR_EN:   intr_en   <= wdata_g;
        IDX_RISE_EN:   rise_en   <= wdata_g;
        IDX_FALL_EN:   fall_en   <= wdata_g;
        IDX_LVLHI_EN:  lvlhi_en  <= wdata_g;
        IDX_LVLLO_EN:  lvllo_en  <= wdata_g;
        IDX_FILTER_EN: filter_en <= wdata_g;
        IDX_MASKED_OUT: begin
          for (int i = 0; i < MASK_N; i++) begin
            if (wdata_i[16+i]) data_out[i] <= wdata_i[i];
          end
        end
        default: ;
      endcase
    end
  end

  // Sticky interrupt state; a new event wins over a same-cycle clear.
  always_ff @(posedge clock) begin
    if (!resetb) begin
      intr_state <= '0;
    end else begin
      intr_state <= (intr_state & ~w1c) | evt;
    end
  end

  // Aggregated interrupt line, one cycle behind the masked state.
  always_ff @(posedge clock) begin
    if (!resetb) begin
      intr_o <= 1'b0;
    end else begin
      intr_o <= |(intr_state & intr_en);
    end
  end

  // Single-cycle response; errors and writes return zero data.
  always_ff @(posedge clock) begin
    if (!resetb) begin
      rsp_valid_o <= 1'b0;
      err_o       <= 1'b0;
      rdata_o     <= '0;
    end else begin
      rsp_valid_o <= req_i;
      err_o       <= req_i & ~addr_ok;
      rdata_o     <= rd_en ? rd_word : '0;
    end
  end

  // Two-flop synchroniser plus one more stage used to detect sync changes.
  always_ff @(posedge clock) begin
    if (!resetb) begin
      sync_1 <= '0;
      sync_2 <= '0;
      sync_d <= '0;
      filt_q <= '0;
    end else begin
      sync_1 <= gpio_i;
      sync_2 <= sync_1;
      sync_d <= sync_2;
      filt_q <= filt;
    end
  end

  // Per-pin glitch filter: a new level must hold for FILTER_CYCLES before it is accepted.
  always_ff @(posedge clock) begin
    if (!resetb) begin
      filt <= '0;
      for (int i = 0; i < NUM_GPIO; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_GPIO; i++) begin
        if (!filter_en[i]) begin
          cnt[i]  <= '0;
          filt[i] <= sync_2[i];
        end else if ((sync_2[i] == filt[i]) || (sync_2[i] != sync_d[i])) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          cnt[i]  <= '0;
          filt[i] <= sync_2[i];
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign gpio_o    = data_out;
  assign gpio_oe_o = dir;

endmodule

// File: tb/tb_gpio_bank_ctrl.sv
// tb/tb_gpio_bank_ctrl.sv - directed table-driven bench for gpio_bank_ctrl
module tb_gpio_bank_ctrl;

  logic        clock = 1'b0;
  logic        resetb;
  logic        req_i;
  logic        we_i;
  logic [5:0]  addr_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;
  logic        rsp_valid_o;
  logic        err_o;
  logic [15:0] gpio_i;
  logic [15:0] gpio_o;
  logic [15:0] gpio_oe_o;
  logic        intr_o;

  int n_total = 0;
  int n_pass  = 0;

  typedef struct {
    bit          we;
    logic [5:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    bit          exp_err;
  } vec_t;

  vec_t vecs [0:22];

  gpio_bank_ctrl #(
    .NUM_GPIO(16),
    .FILTER_CYCLES(16),
    .CNT_W(16)
  ) dut (
    .clock(clock),
    .resetb(resetb),
    .req_i(req_i),
    .we_i(we_i),
    .addr_i(addr_i),
    .wdata_i(wdata_i),
    .rdata_o(rdata_o),
    .rsp_valid_o(rsp_valid_o),
    .err_o(err_o),
    .gpio_i(gpio_i),
    .gpio_o(gpio_o),
    .gpio_oe_o(gpio_oe_o),
    .intr_o(intr_o)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  // Called at a negedge; returns at the next negedge with the response sampled.
  task automatic bus(input bit we, input logic [5:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output logic er, output logic vl);
    req_i   = 1'b1;
    we_i    = we;
    addr_i  = a;
    wdata_i = d;
    @(negedge clock);
    req_i   = 1'b0;
    we_i    = 1'b0;
    addr_i  = '0;
    wdata_i = '0;
    rd = rdata_o;
    er = err_o;
    vl = rsp_valid_o;
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    logic [31:0] rd;
    logic er, vl;
    bus(1'b1, a, d, rd, er, vl);
  endtask

  task automatic rd_chk(input string nm, input logic [5:0] a, input logic [31:0] exp);
    logic [31:0] rd;
    logic er, vl;
    bus(1'b0, a, '0, rd, er, vl);
    chk({nm, " rsp_valid"}, {31'b0, vl}, 32'h1);
    chk(nm, rd, exp);
  endtask

  task automatic run_vecs(input int lo, input int hi);
    logic [31:0] rd;
    logic er, vl;
    for (int i = lo; i <= hi; i++) begin
      bus(vecs[i].we, vecs[i].addr, vecs[i].wdata, rd, er, vl);
      chk($sformatf("vec%0d rsp_valid", i), {31'b0, vl}, 32'h1);
      chk($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rdata);
      chk($sformatf("vec%0d err", i), {31'b0, er}, {31'b0, vecs[i].exp_err});
      @(negedge clock);
      chk($sformatf("vec%0d rsp_valid one cycle", i), {31'b0, rsp_valid_o}, 32'h0);
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic er, vl;

    // Reset reads: every register zero, DATA_IN follows the held-high pads.
    for (int i = 0; i <= 10; i++) vecs[i] = '{0, 6'(i * 4), 32'h0, 32'h0, 0};
    vecs[0].exp_rdata = 32'h0000_FFFF;
    // Direction / data-out writes, upper bits ignored.
    vecs[11] = '{1, 6'h08, 32'h0000_FFFF, 32'h0, 0};
    vecs[12] = '{1, 6'h04, 32'hFFFF_00FF, 32'h0, 0};
    vecs[13] = '{0, 6'h04, 32'h0,         32'h0000_00FF, 0};
    vecs[14] = '{0, 6'h08, 32'h0,         32'h0000_FFFF, 0};
    // After the masked write.
    vecs[15] = '{0, 6'h04, 32'h0,         32'h0000_0AFF, 0};
    vecs[16] = '{0, 6'h28, 32'h0,         32'h0, 0};
    vecs[17] = '{1, 6'h00, 32'h0000_1234, 32'h0, 0};
    vecs[18] = '{0, 6'h00, 32'h0,         32'h0, 0};
    // Bad addresses.
    vecs[19] = '{0, 6'h30, 32'h0,         32'h0, 1};
    vecs[20] = '{1, 6'h2C, 32'h0000_FFFF, 32'h0, 1};
    vecs[21] = '{0, 6'h04, 32'h0,         32'h0000_0AFF, 0};
    vecs[22] = '{0, 6'h3C, 32'h0,         32'h0, 1};

    resetb  = 1'b0;
    req_i   = 1'b0;
    we_i    = 1'b0;
    addr_i  = '0;
    wdata_i = '0;
    gpio_i  = 16'hFFFF;
    repeat (5) @(negedge clock);
    chk("reset gpio_o", {16'b0, gpio_o}, 32'h0);
    chk("reset gpio_oe_o", {16'b0, gpio_oe_o}, 32'h0);
    chk("reset intr_o", {31'b0, intr_o}, 32'h0);
    chk("reset rsp_valid_o", {31'b0, rsp_valid_o}, 32'h0);
    resetb = 1'b1;
    repeat (3) @(negedge clock);
    run_vecs(0, 10);

    gpio_i = 16'h0000;
    repeat (5) @(negedge clock);

    run_vecs(11, 14);
    chk("gpio_oe after DIR", {16'b0, gpio_oe_o}, 32'h0000_FFFF);
    chk("gpio_o after DATA_OUT", {16'b0, gpio_o}, 32'h0000_00FF);
    bus(1'b1, 6'h28, 32'h0F00_0A00, rd, er, vl);
    chk("masked write rdata", rd, 32'h0);
    chk("gpio_o after masked write", {16'b0, gpio_o}, 32'h0000_0AFF);
    run_vecs(15, 18);

    // Rising edge on pin 0, filter off: state at cycle 4, intr_o at cycle 5.
    wr(6'h14, 32'h1);
    wr(6'h0C, 32'h1);
    gpio_i[0] = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clock);
      chk($sformatf("edge intr_o cycle %0d", k), {31'b0, intr_o}, {31'b0, k >= 5});
    end
    rd_chk("edge INTR_STATE", 6'h10, 32'h1);
    wr(6'h10, 32'h1);
    chk("intr_o one cycle after w1c", {31'b0, intr_o}, 32'h1);
    @(negedge clock);
    chk("intr_o two cycles after w1c", {31'b0, intr_o}, 32'h0);
    rd_chk("INTR_STATE after w1c", 6'h10, 32'h0);
    gpio_i[0] = 1'b0;
    wr(6'h14, 32'h0);
    wr(6'h0C, 32'h0);
    repeat (5) @(negedge clock);

    // Glitch filter on pin 1.
    wr(6'h24, 32'h2);
    wr(6'h14, 32'h2);
    wr(6'h0C, 32'h2);
    gpio_i[1] = 1'b1;
    repeat (10) @(negedge clock);
    gpio_i[1] = 1'b0;
    repeat (30) @(negedge clock);
    rd_chk("short pulse DATA_IN", 6'h00, 32'h0);
    rd_chk("short pulse INTR_STATE", 6'h10, 32'h0);
    chk("short pulse intr_o", {31'b0, intr_o}, 32'h0);

    gpio_i[1] = 1'b1;
    repeat (18) @(negedge clock);
    bus(1'b0, 6'h00, '0, rd, er, vl);
    chk("long pulse DATA_IN at edge+18", rd, 32'h0);
    bus(1'b0, 6'h00, '0, rd, er, vl);
    chk("long pulse DATA_IN at edge+19", rd, 32'h2);
    gpio_i[1] = 1'b0;
    rd_chk("long pulse INTR_STATE", 6'h10, 32'h2);
    chk("long pulse intr_o", {31'b0, intr_o}, 32'h1);
    wr(6'h10, 32'h2);
    repeat (25) @(negedge clock);
    wr(6'h24, 32'h0);
    wr(6'h14, 32'h0);
    wr(6'h0C, 32'h0);
    rd_chk("INTR_STATE after filter test", 6'h10, 32'h0);

    // Level-high on pin 2 colliding with a W1C.
    wr(6'h1C, 32'h4);
    wr(6'h0C, 32'h4);
    gpio_i[2] = 1'b1;
    repeat (6) @(negedge clock);
    chk("level intr_o", {31'b0, intr_o}, 32'h1);
    wr(6'h10, 32'h4);
    chk("collision intr_o +1", {31'b0, intr_o}, 32'h1);
    @(negedge clock);
    chk("collision intr_o +2", {31'b0, intr_o}, 32'h1);
    rd_chk("collision INTR_STATE", 6'h10, 32'h4);

    run_vecs(19, 22);

    // Reset in the same cycle as a read request drops the response.
    req_i  = 1'b1;
    we_i   = 1'b0;
    addr_i = 6'h04;
    resetb = 1'b0;
    @(negedge clock);
    req_i  = 1'b0;
    addr_i = '0;
    chk("midreset rsp_valid_o", {31'b0, rsp_valid_o}, 32'h0);
    chk("midreset rdata_o", rdata_o, 32'h0);
    chk("midreset err_o", {31'b0, err_o}, 32'h0);
    chk("midreset gpio_o", {16'b0, gpio_o}, 32'h0);
    chk("midreset gpio_oe_o", {16'b0, gpio_oe_o}, 32'h0);
    chk("midreset intr_o", {31'b0, intr_o}, 32'h0);
    @(negedge clock);
    resetb = 1'b1;
    gpio_i = 16'h0000;
    rd_chk("post-reset DATA_OUT", 6'h04, 32'h0);
    rd_chk("post-reset LVLHI_EN", 6'h1C, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
